// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - conflict-mode constants and per-bit next-state rule for sr_bank
package sr_bank_pkg;

  localparam int SR_HOLD    = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_RST_DOM = 2;
  localparam int SR_TOGGLE  = 3;

  // Modes outside 0..3 fall through to hold on S=R=1.
  function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one set/reset channel with load, enable, conflict and change flags
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int   CONFLICT_MODE = SR_HOLD,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic load,
  input  logic d,
  output logic q,
  output logic conflict,
  output logic changed
);

  logic q_nxt;

  assign q_nxt = sr_next(q, s, r, CONFLICT_MODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RESET_BIT;
      conflict <= 1'b0;
      changed  <= 1'b0;
    end else if (load) begin
      q        <= d;
      conflict <= 1'b0;
      changed  <= d ^ q;
    end else if (en) begin
      q        <= q_nxt;
      conflict <= s & r;
      changed  <= q_nxt ^ q;
    end else begin
      conflict <= 1'b0;
      changed  <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_bank.sv
// rtl/sr_bank.sv - bank of clocked SR flags with saturating conflict-event counter
module sr_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = SR_HOLD,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic conflict_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .CONFLICT_MODE(CONFLICT_MODE),
      .RESET_BIT    (RESET_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .s       (S[i]),
      .r       (R[i]),
      .load    (load),
      .d       (D[i]),
      .q       (Q[i]),
      .conflict(conflict[i]),
      .changed (changed[i])
    );
  end

  assign Qbar = ~Q;

  // Load pre-empts the S/R update, so its conflicts are never counted.
  assign conflict_hit = en & ~load & (|(S & R));

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_cnt) begin
      conflict_cnt <= '0;
    end else if (conflict_hit && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_bank.sv
// tb/tb_sr_bank.sv - self-checking bench for sr_bank, one instance per conflict mode
module tb_sr_bank;

  logic       clk = 1'b0;
  logic       rst, en, load, clr_cnt;
  logic [3:0] S, R, D;

  logic [3:0] q_o[4], qb_o[4], cf_o[4], ch_o[4];
  logic [1:0] cnt_o[4];

  int checks = 0;
  int errors = 0;

  // Reference state per mode instance
  logic [3:0] mq[4], mcf[4], mch[4];
  int         mcnt[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_bank #(
      .WIDTH        (4),
      .CONFLICT_MODE(g),
      .RESET_VAL    (4'b0101),
      .CNT_W        (2)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .S           (S),
      .R           (R),
      .load        (load),
      .D           (D),
      .clr_cnt     (clr_cnt),
      .Q           (q_o[g]),
      .Qbar        (qb_o[g]),
      .conflict    (cf_o[g]),
      .changed     (ch_o[g]),
      .conflict_cnt(cnt_o[g])
    );
  end

  function automatic logic [17:0] obs(input int m);
    return {q_o[m], qb_o[m], cf_o[m], ch_o[m], cnt_o[m]};
  endfunction

  function automatic logic [17:0] mdl(input int m);
    return {mq[m], ~mq[m], mcf[m], mch[m], 2'(mcnt[m])};
  endfunction

  task automatic cycle(input logic rst_v, input logic en_v, input logic load_v, input logic clr_v,
                       input logic [3:0] s_v, input logic [3:0] r_v, input logic [3:0] d_v);
    logic [3:0] both_val, nq;
    rst = rst_v; en = en_v; load = load_v; clr_cnt = clr_v;
    S = s_v; R = r_v; D = d_v;
    @(posedge clk);
    for (int m = 0; m < 4; m++) begin
      case (m)
        0:       both_val = mq[m];
        1:       both_val = 4'b1111;
        2:       both_val = 4'b0000;
        default: both_val = ~mq[m];
      endcase
      if (rst_v) begin
        mq[m] = 4'b0101; mcf[m] = '0; mch[m] = '0; mcnt[m] = 0;
      end else if (load_v) begin
        mch[m] = d_v ^ mq[m]; mq[m] = d_v; mcf[m] = '0;
        if (clr_v) mcnt[m] = 0;
      end else if (en_v) begin
        nq = (mq[m] & ~s_v & ~r_v) | (s_v & ~r_v) | (s_v & r_v & both_val);
        mcf[m] = s_v & r_v; mch[m] = nq ^ mq[m]; mq[m] = nq;
        if (clr_v) mcnt[m] = 0;
        else if (mcf[m] != 0) mcnt[m] = (mcnt[m] < 3) ? mcnt[m] + 1 : 3;
      end else begin
        mcf[m] = '0; mch[m] = '0;
        if (clr_v) mcnt[m] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 1, 1, 0, 4'b1111, 4'b1111, 4'b1010);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (obs(m) !== {4'b0101, 4'b1010, 4'b0000, 4'b0000, 2'd0}) begin
        errors++;
        $display("FAIL reset mode%0d: got %h want %h", m, obs(m), {4'b0101, 4'b1010, 10'd0});
      end
    end
  endtask

  task automatic test_basic;
    cycle(0, 1, 0, 0, 4'b1010, 4'b0001, 4'b0000);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (obs(m) !== {4'b1110, 4'b0001, 4'b0000, 4'b1011, 2'd0}) begin
        errors++;
        $display("FAIL basic_set mode%0d: got %h want %h", m, obs(m),
                 {4'b1110, 4'b0001, 4'b0000, 4'b1011, 2'd0});
      end
    end
    cycle(0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (obs(m) !== {4'b1110, 4'b0001, 4'b0000, 4'b0000, 2'd0}) begin
        errors++;
        $display("FAIL basic_hold mode%0d: got %h want %h", m, obs(m),
                 {4'b1110, 4'b0001, 10'd0});
      end
    end
  endtask

  task automatic test_conflict;
    logic [3:0] exp_q[4];
    exp_q = '{4'b0101, 4'b1111, 4'b0000, 4'b1010};
    cycle(1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    cycle(0, 1, 0, 0, 4'b1111, 4'b1111, 4'b0000);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (obs(m) !== {exp_q[m], ~exp_q[m], 4'b1111, exp_q[m] ^ 4'b0101, 2'd1}) begin
        errors++;
        $display("FAIL conflict mode%0d: got %h want %h", m, obs(m),
                 {exp_q[m], ~exp_q[m], 4'b1111, exp_q[m] ^ 4'b0101, 2'd1});
      end
    end
  endtask

  task automatic test_load;
    logic [3:0] prev_q[4];
    prev_q = '{4'b0101, 4'b1111, 4'b0000, 4'b1010};
    cycle(0, 1, 1, 0, 4'b1111, 4'b1111, 4'b0011);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (obs(m) !== {4'b0011, 4'b1100, 4'b0000, 4'b0011 ^ prev_q[m], 2'd1}) begin
        errors++;
        $display("FAIL load_en mode%0d: got %h want %h", m, obs(m),
                 {4'b0011, 4'b1100, 4'b0000, 4'b0011 ^ prev_q[m], 2'd1});
      end
    end
    cycle(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1100);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (obs(m) !== {4'b1100, 4'b0011, 4'b0000, 4'b1111, 2'd1}) begin
        errors++;
        $display("FAIL load_noen mode%0d: got %h want %h", m, obs(m),
                 {4'b1100, 4'b0011, 4'b0000, 4'b1111, 2'd1});
      end
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt;
    cycle(1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 0, 0, 4'b1111, 4'b1111, 4'b0000);
      exp_cnt = (k < 2) ? 2'(k + 1) : 2'd3;
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (cnt_o[m] !== exp_cnt || obs(m) !== mdl(m)) begin
          errors++;
          $display("FAIL saturate k%0d mode%0d: got %h want cnt %0d state %h", k, m, obs(m),
                   exp_cnt, mdl(m));
        end
      end
    end
    cycle(0, 1, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (cnt_o[m] !== 2'd0 || cf_o[m] !== 4'b1111) begin
        errors++;
        $display("FAIL clr_wins mode%0d: got cnt %0d conflict %b want 0 1111", m, cnt_o[m], cf_o[m]);
      end
    end
  endtask

  task automatic test_reset_mid;
    cycle(1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 4'b1111, 4'b1111, 4'b0000);
    cycle(1, 1, 1, 1, 4'b1111, 4'b1111, 4'b1001);
    checks++;
    if (q_o[3] !== 4'b0101 || cnt_o[3] !== 2'd0 || ch_o[3] !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: got Q %b cnt %0d changed %b want 0101 0 0000", q_o[3], cnt_o[3], ch_o[3]);
    end
    cycle(0, 1, 0, 0, 4'b1111, 4'b1111, 4'b0000);
    checks++;
    if (q_o[3] !== 4'b1010 || cnt_o[3] !== 2'd1) begin
      errors++;
      $display("FAIL reset_release: got Q %b cnt %0d want 1010 1", q_o[3], cnt_o[3]);
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (obs(m) !== mdl(m)) begin
        errors++;
        $display("FAIL reset_release mode%0d: got %h want %h", m, obs(m), mdl(m));
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(31) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
            ($urandom_range(15) == 0), 4'($urandom), 4'($urandom), 4'($urandom));
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (obs(m) !== mdl(m)) begin
          errors++;
          $display("FAIL random k%0d mode%0d: got %h want %h", k, m, obs(m), mdl(m));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    S = '0; R = '0; D = '0;
    #2;
    test_reset();
    test_basic();
    test_conflict();
    test_load();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_bank.md
# sr_bank

Parametrised bank of `WIDTH` independent clocked set/reset flip-flops. It generalises the single-bit clocked SR flip-flop with:
- selectable S=R=1 conflict resolution (hold, set-dominant, reset-dominant, toggle/JK),
- clock enable, synchronous parallel load, per-channel change pulses,
- a saturating conflict-event counter.

Used as the status/flag register stage for multi-bit lab designs, where each bit is set and cleared by independent event strobes.

## Interface

Parameters:
- `WIDTH`, 8, number of channels.
- `CONFLICT_MODE`, 0, S=R=1 behaviour: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- `RESET_VAL`, 0 (`WIDTH` bits), value loaded into `Q` on reset.
- `CNT_W`, 8, width of `conflict_cnt`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `en`  in  1  clock enable for S/R updates.
- `S`  in  WIDTH  per-channel set.
- `R`  in  WIDTH  per-channel reset.
- `load`  in  1  synchronous parallel load of `D`; ignores `en`.
- `D`  in  WIDTH  parallel load data.
- `clr_cnt`  in  1  synchronous clear of `conflict_cnt`.
- `Q`  out  WIDTH  registered state.
- `Qbar`  out  WIDTH  always `~Q`, driven combinationally from the register.
- `conflict`  out  WIDTH  registered; bit i = 1 when channel i saw S=R=1 on an applied S/R update in the previous cycle.
- `changed`  out  WIDTH  registered; bit i = 1 for one cycle when `Q[i]` changed at the last edge.
- `conflict_cnt`  out  CNT_W  saturating count of cycles with any applied conflict.

## Operation

Next-state priority per edge: `rst` > `load` > (`en` and S/R) > hold.

- **`rst`=1:**
  - `Q`=`RESET_VAL`, `Qbar`=`~RESET_VAL`.
  - `conflict`=0, `changed`=0, `conflict_cnt`=0.
  - All other inputs are ignored.
- **`load`=1:**
  - `Q`=`D`.
  - `conflict`=0; `conflict_cnt` unchanged unless cleared by `clr_cnt`.
  - `changed`=`D ^ Q_old`.
- **`en`=1, `load`=0**, per channel:
  - S=0, R=0: hold.
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=1, R=1: resolved by `CONFLICT_MODE` (hold / 1 / 0 / `~Q`).
- **`en`=0, `load`=0:** `Q` holds, `conflict`=0, `changed`=0.
- **`conflict`:** next value = `S & R` when an S/R update is applied, else 0.
- **`conflict_cnt`:**
  - Increments by 1 when an S/R update is applied and `|(S & R)`.
  - Saturates at 2^CNT_W−1; no wrap.
  - `clr_cnt`=1 forces 0, and wins over a simultaneous increment.
- **`changed`:** `Q_next ^ Q` in all non-reset cases, so it is a 1-cycle pulse aligned with the new `Q`.
- Illegal `CONFLICT_MODE` values (>3) behave as hold.

## Timing

- Latency: inputs sampled at edge k; `Q`, `Qbar`, `conflict`, `changed`, `conflict_cnt` valid after edge k.
- No combinational path from any input to any output. `Qbar` depends only on the `Q` register.
- Reset asserted mid-operation overrides a same-cycle `load`, `S`/`R`, and `clr_cnt`. The first edge after `rst` deasserts applies inputs normally.
- No handshake; one update per enabled cycle; back-to-back updates are supported every cycle.
- Toggle mode with S=R=1 held and `en`=1 toggles every cycle, and the counter increments every cycle until saturation.

## Structure

- Package `sr_bank_pkg`:
  - mode constants `SR_HOLD`=0, `SR_SET_DOM`=1, `SR_RST_DOM`=2, `SR_TOGGLE`=3,
  - function `sr_next(q, s, r, mode)` returning the 1-bit next state.
- Sub-module `sr_cell`:
  - one channel: register, `rst`/`load`/`en` priority, `conflict` and `changed` bits.
  - Instantiated `WIDTH` times in a generate loop.
- Top level holds the OR-reduction and the saturating `conflict_cnt` counter.

## Test plan

Bench uses `WIDTH`=4 and `RESET_VAL`=4'b0101.

1. **Reset:** `rst`=1 for one edge with S=R=1111 and `load`=1 → `Q`=0101, `Qbar`=1010, `conflict`=0, `changed`=0, `conflict_cnt`=0.
2. **Basic set/reset:** from `Q`=0101, `en`=1, S=1010, R=0001 → `Q`=1110, `changed`=1011, `conflict`=0. Then `en`=0 with S=0001 → `Q` stays 1110, `changed`=0.
3. **Conflict per mode:** from `Q`=0101, `en`=1, S=R=1111, once per `CONFLICT_MODE`:
   - mode 0 → `Q`=0101,
   - mode 1 → `Q`=1111,
   - mode 2 → `Q`=0000,
   - mode 3 → `Q`=1010.
   - In every mode: `conflict`=1111, `conflict_cnt`=1.
4. **Load priority:** `load`=1, `D`=0011, `en`=1, S=R=1111 → `Q`=0011, `conflict`=0, `conflict_cnt` unchanged. `load`=1 with `en`=0 also loads.
5. **Counter saturation:** `CNT_W`=2, five consecutive conflict cycles → `conflict_cnt` = 1, 2, 3, 3, 3. Then `clr_cnt`=1 together with a conflict → 0.
6. **Reset mid-operation:** mode 3, S=R=1111 toggling for 3 cycles, then `rst`=1 → next edge `Q`=0101, `conflict_cnt`=0. Release `rst` → toggling resumes with `Q`=1010 and `conflict_cnt`=1.
